// File: rtl/riscv_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_pkg
// Shared encodings for the fetch/data memory arbiter.
//   - arb_state_t   : arbiter FSM states (2 bits)
//   - ARB_GNT_*     : encodings of the o_arb_grant owner field
//   - ARB_FETCH_BSEL: byte-lane mask used for every instruction fetch
// -----------------------------------------------------------------------------
package riscv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_BUSY_I = 2'b01,
        ARB_BUSY_D = 2'b10,
        ARB_RESP   = 2'b11
    } arb_state_t;

    localparam logic [1:0] ARB_GNT_NONE = 2'b00;
    localparam logic [1:0] ARB_GNT_IF   = 2'b01;
    localparam logic [1:0] ARB_GNT_DM   = 2'b10;

    // Fetches are always full 32-bit words.
    localparam logic [3:0] ARB_FETCH_BSEL = 4'b1111;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter_if
// Bundles every handshake/bus signal of the memory arbiter. Signal names are
// given from the arbiter's point of view (i_ = into arbiter, o_ = out of it).
//   Fetch port : i_if_req, i_if_addr, o_if_rdata, o_if_valid
//   Data port  : i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_byte_sel,
//                o_dm_rdata, o_dm_valid
//   Memory port: o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_byte_sel,
//                i_mem_ready, i_mem_rdata
//   Status     : o_arb_stall, o_arb_grant, o_arb_err
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding core + memory model
// -----------------------------------------------------------------------------
interface riscv_mem_arbiter_if #(
    parameter int XLEN = 32
);
    // Fetch requester
    logic            i_if_req;
    logic [XLEN-1:0] i_if_addr;
    logic [XLEN-1:0] o_if_rdata;
    logic            o_if_valid;

    // Data requester
    logic            i_dm_req;
    logic            i_dm_we;
    logic [XLEN-1:0] i_dm_addr;
    logic [XLEN-1:0] i_dm_wdata;
    logic [3:0]      i_dm_byte_sel;
    logic [XLEN-1:0] o_dm_rdata;
    logic            o_dm_valid;

    // Shared memory
    logic            o_mem_req;
    logic            o_mem_we;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] o_mem_wdata;
    logic [3:0]      o_mem_byte_sel;
    logic            i_mem_ready;
    logic [XLEN-1:0] i_mem_rdata;

    // Status
    logic            o_arb_stall;
    logic [1:0]      o_arb_grant;
    logic            o_arb_err;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_rdata, o_if_valid,
        input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_byte_sel,
        output o_dm_rdata, o_dm_valid,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_byte_sel,
        input  i_mem_ready, i_mem_rdata,
        output o_arb_stall, o_arb_grant, o_arb_err
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_rdata, o_if_valid,
        output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_byte_sel,
        input  o_dm_rdata, o_dm_valid,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_byte_sel,
        output i_mem_ready, i_mem_rdata,
        input  o_arb_stall, o_arb_grant, o_arb_err
    );

endinterface

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
// Shares one single-port memory between the RV32I fetch port and the MEM-stage
// data port. One access is in flight at a time; data has fixed priority over
// fetch. A completion is signalled by a one-cycle valid pulse to the owner, and
// the pipeline is stalled while any requester is still waiting.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : riscv_mem_arbiter_if.slave (fetch, data, memory, status)
// Parameters:
//   XLEN           : data/address width
//   TIMEOUT_CYCLES : busy cycles without i_mem_ready before abort (1..255)
// -----------------------------------------------------------------------------
module riscv_mem_arbiter
    import riscv_mem_arbiter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    riscv_mem_arbiter_if.slave    bus
);

    // Counter value seen in the last permitted busy cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    arb_state_t      r_state;
    logic [7:0]      r_tmo_cnt;

    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [3:0]      r_mem_byte_sel;

    logic [XLEN-1:0] r_if_rdata;
    logic            r_if_valid;
    logic [XLEN-1:0] r_dm_rdata;
    logic            r_dm_valid;

    logic [1:0]      r_grant;
    logic            r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ARB_IDLE;
            r_tmo_cnt      <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_byte_sel <= '0;
            r_if_rdata     <= '0;
            r_if_valid     <= 1'b0;
            r_dm_rdata     <= '0;
            r_dm_valid     <= 1'b0;
            r_grant        <= ARB_GNT_NONE;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // Data wins: the MEM stage holds the older instruction.
                    if (bus.i_dm_req) begin
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= bus.i_dm_we;
                        r_mem_addr     <= bus.i_dm_addr;
                        r_mem_wdata    <= bus.i_dm_wdata;
                        r_mem_byte_sel <= bus.i_dm_byte_sel;
                        r_grant        <= ARB_GNT_DM;
                        r_state        <= ARB_BUSY_D;
                    end else if (bus.i_if_req) begin
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= bus.i_if_addr;
                        r_mem_wdata    <= '0;
                        r_mem_byte_sel <= ARB_FETCH_BSEL;
                        r_grant        <= ARB_GNT_IF;
                        r_state        <= ARB_BUSY_I;
                    end
                end

                ARB_BUSY_I, ARB_BUSY_D: begin
                    // Ready takes precedence, so a response arriving in the
                    // final permitted cycle still completes normally.
                    if (bus.i_mem_ready) begin
                        if (r_state == ARB_BUSY_I) begin
                            r_if_rdata <= bus.i_mem_rdata;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_dm_rdata <= r_mem_we ? '0 : bus.i_mem_rdata;
                            r_dm_valid <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_grant   <= ARB_GNT_NONE;
                        r_state   <= ARB_RESP;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        // Abort: complete the owner with zero data and flag it.
                        if (r_state == ARB_BUSY_I) begin
                            r_if_rdata <= '0;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_dm_rdata <= '0;
                            r_dm_valid <= 1'b1;
                        end
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_grant   <= ARB_GNT_NONE;
                        r_state   <= ARB_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end

                ARB_RESP: begin
                    // Valid was raised on entry; drop it after one cycle.
                    r_if_valid <= 1'b0;
                    r_dm_valid <= 1'b0;
                    r_grant    <= ARB_GNT_NONE;
                    r_tmo_cnt  <= '0;
                    r_state    <= ARB_IDLE;
                end

                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.o_mem_req      = r_mem_req;
    assign bus.o_mem_we       = r_mem_we;
    assign bus.o_mem_addr     = r_mem_addr;
    assign bus.o_mem_wdata    = r_mem_wdata;
    assign bus.o_mem_byte_sel = r_mem_byte_sel;

    assign bus.o_if_rdata     = r_if_rdata;
    assign bus.o_if_valid     = r_if_valid;
    assign bus.o_dm_rdata     = r_dm_rdata;
    assign bus.o_dm_valid     = r_dm_valid;

    assign bus.o_arb_grant    = r_grant;
    assign bus.o_arb_err      = r_err;

    // A requester stops stalling in the same cycle its valid pulse appears.
    assign bus.o_arb_stall    = (bus.i_if_req & ~r_if_valid) |
                                (bus.i_dm_req & ~r_dm_valid);

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the pipelined RV32I core's instruction-fetch port and its data (MEM-stage) port.
- Serialises accesses through a request/ready handshake and returns read data to the correct requester.
- Drives a pipeline stall while any requester is still waiting, so the core runs on one shared memory.
- Sits between the core top (fetch PC and EM-stage memory signals) and the memory model/bus.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYCLES, 16, maximum cycles in a BUSY state without i_mem_ready before the access is aborted; range 1..255.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_if_req  in  1  fetch request, held until o_if_valid.
- i_if_addr  in  XLEN  fetch address (PC).
- o_if_rdata  out  XLEN  fetched instruction.
- o_if_valid  out  1  one-cycle fetch completion pulse.
- i_dm_req  in  1  data request, held until o_dm_valid.
- i_dm_we  in  1  data write enable.
- i_dm_addr  in  XLEN  data address.
- i_dm_wdata  in  XLEN  store data.
- i_dm_byte_sel  in  4  store byte lanes.
- o_dm_rdata  out  XLEN  load data.
- o_dm_valid  out  1  one-cycle data completion pulse.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  XLEN  memory address.
- o_mem_wdata  out  XLEN  memory write data.
- o_mem_byte_sel  out  4  memory byte lanes; 4'b1111 for fetch.
- i_mem_ready  in  1  memory accepts or completes the access this cycle.
- i_mem_rdata  in  XLEN  read data, valid when i_mem_ready=1.
- o_arb_stall  out  1  pipeline stall, combinational.
- o_arb_grant  out  2  current owner: 00 none, 01 fetch, 10 data.
- o_arb_err  out  1  sticky timeout flag.

Behaviour:
- Reset values (synchronous, i_rst=1): state IDLE; all o_mem_* = 0; o_if_valid = o_dm_valid = 0; rdata outputs = 0; o_arb_grant = 00; o_arb_err = 0; timeout counter = 0.
- Reset mid-access: o_mem_req drops on the next edge. The memory side tolerates the abandoned request. No valid pulse is issued for it.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - i_dm_req=1 → register dm fields onto o_mem_*, o_mem_req=1, grant=10, go to BUSY_D.
  - Else i_if_req=1 → register i_if_addr, we=0, byte_sel=4'b1111, o_mem_req=1, grant=01, go to BUSY_I.
  - Data has fixed priority: the MEM stage holds the older instruction.
- BUSY_I / BUSY_D:
  - All o_mem_* stay stable and the counter increments.
  - On i_mem_ready=1: capture i_mem_rdata into the owner's rdata register. Stores also pass through RESP; their rdata is 0. Deassert o_mem_req and go to RESP.
  - On counter = TIMEOUT_CYCLES-1 with no ready: set o_arb_err, load the owner's rdata with 0, deassert o_mem_req, go to RESP.
- RESP: pulse the owner's valid for exactly one cycle, grant=00, clear the counter, go to IDLE unconditionally.
- Requests present in RESP are not sampled until IDLE.
- Minimum access time with zero-wait memory (ready in the same cycle as o_mem_req): request seen in IDLE at cycle c0 → o_mem_req at c1 → valid at c2 → IDLE at c3.
- o_arb_stall = (i_if_req & ~o_if_valid) | (i_dm_req & ~o_dm_valid).
- Simultaneous if/dm requests: data is served first, fetch next. Fetch keeps stalling throughout.
- A requester dropping its request while BUSY is a protocol violation: the access completes, and the valid pulse is still produced and ignored.
- o_arb_err is cleared only by i_rst.

Decomposition:
- Shared configs header additions:
  - state encodings ARB_IDLE/BUSY_I/BUSY_D/RESP (2 bits);
  - grant encodings ARB_GNT_NONE/IF/DM;
  - fetch byte-select constant 4'b1111.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Fetch only, zero-wait memory: i_if_req=1, addr=0x0000_0010, memory returns 0x0000_0013 → o_mem_req at c1 with addr 0x10, byte_sel 1111; o_if_valid pulse at c2 with rdata 0x13; stall high c0–c1, low at c2.
- Simultaneous requests: if addr 0x20 and dm load addr 0x100 (memory data 0xDEADBEEF) both at c0 → dm served first (dm_valid c2, rdata 0xDEADBEEF), then fetch issued at c4 (if_valid c5); grant sequence 10, 00, 00, 01.
- Store: dm_we=1, addr 0x200, wdata 0x12345678, byte_sel 0011 → o_mem_we=1 and fields match; memory ready after 3 wait cycles → o_dm_valid after the ready edge; o_dm_rdata=0.
- Timeout: TIMEOUT_CYCLES=4, memory never ready → o_mem_req high exactly 4 cycles, then o_arb_err=1 and o_if_valid pulse with rdata 0; o_arb_err remains 1 across later successful accesses.
- Reset mid-access: assert i_rst during BUSY_D → next cycle o_mem_req=0, grant=00, no valid pulse; after release, a fresh fetch completes normally.
- Back-to-back fetches: requester changes addr 0x0→0x4→0x8 on each valid → each access takes 3 cycles; no duplicate memory requests to the same address.
